// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the memory port arbiter and
// the single-port memory.
interface mem_port_arbiter_if;
   logic        if_req;
   logic [63:0] if_addr;
   logic        if_done;
   logic [31:0] if_rdata;

   logic        d_req;
   logic        d_we;
   logic [63:0] d_addr;
   logic [63:0] d_wdata;
   logic [3:0]  d_size;
   logic        d_done;
   logic [63:0] d_rdata;

   logic [63:0] mem_addr;
   logic        mem_re;
   logic        mem_we;
   logic [63:0] mem_wdata;
   logic [3:0]  mem_size;
   logic [63:0] mem_rdata;

   logic        stall_if;
   logic        stall_mem;

   // Requester/memory side of the bundle
   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_size, mem_rdata,
      input  if_done, if_rdata, d_done, d_rdata,
             mem_addr, mem_re, mem_we, mem_wdata, mem_size, stall_if, stall_mem
   );

   // Arbiter side of the bundle
   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_size, mem_rdata,
      output if_done, if_rdata, d_done, d_rdata,
             mem_addr, mem_re, mem_we, mem_wdata, mem_size, stall_if, stall_mem
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Serialises instruction fetch and load/store onto one single-port memory.
// Data wins unless it has starved a pending fetch for MAX_D_STREAK grants.
module mem_port_arbiter #(
   parameter int unsigned MEM_LAT      = 2,
   parameter int unsigned MAX_D_STREAK = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   mem_port_arbiter_if.slave  bus
);

   localparam int unsigned LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam int unsigned SW = $clog2(MAX_D_STREAK + 1);
   localparam logic [LW-1:0] LAT_LAST   = LW'(MEM_LAT - 1);
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);
   localparam logic [3:0]    FETCH_SIZE = 4'd8;

   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

   state_t        r_state;
   state_t        w_next;
   logic [LW-1:0] r_lat;
   logic [SW-1:0] r_streak;
   logic          r_owner_d;
   logic          r_we;
   logic [63:0]   r_addr;
   logic [63:0]   r_wdata;
   logic [3:0]    r_size;
   logic [31:0]   r_if_rdata;
   logic [63:0]   r_d_rdata;

   logic          w_grant_d;
   logic          w_grant_i;
   logic          w_busy;
   logic          w_last;
   logic          w_mem_re;
   logic          w_mem_we;
   logic          w_if_done;
   logic          w_d_done;

   assign w_busy = (r_state == BUSY_I) || (r_state == BUSY_D);
   assign w_last = (r_lat == LAT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      w_grant_d = 1'b0;
      w_grant_i = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.d_req && (!bus.if_req || (r_streak < STREAK_MAX))) begin
               w_grant_d = 1'b1;
               w_next    = BUSY_D;
            end else if (bus.if_req) begin
               w_grant_i = 1'b1;
               w_next    = BUSY_I;
            end
         end
         BUSY_I, BUSY_D: if (w_last) w_next = RESP;
         RESP:           w_next = IDLE;
         default:        w_next = IDLE;
      endcase
   end

   // Write strobe only on the first BUSY cycle so a store lands exactly once
   always_comb begin
      w_mem_re  = 1'b0;
      w_mem_we  = 1'b0;
      w_if_done = 1'b0;
      w_d_done  = 1'b0;
      case (r_state)
         BUSY_I: w_mem_re = 1'b1;
         BUSY_D: begin
            w_mem_re = ~r_we;
            w_mem_we = r_we && (r_lat == '0);
         end
         RESP: begin
            w_if_done = ~r_owner_d;
            w_d_done  = r_owner_d;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lat      <= '0;
         r_streak   <= '0;
         r_owner_d  <= 1'b0;
         r_we       <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_size     <= '0;
         r_if_rdata <= '0;
         r_d_rdata  <= '0;
      end else begin
         if (w_grant_d) begin
            r_owner_d <= 1'b1;
            r_we      <= bus.d_we;
            r_addr    <= bus.d_addr;
            r_wdata   <= bus.d_wdata;
            r_size    <= bus.d_size;
            r_lat     <= '0;
            if (!bus.if_req)                r_streak <= '0;
            else if (r_streak != STREAK_MAX) r_streak <= r_streak + SW'(1);
         end else if (w_grant_i) begin
            r_owner_d <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= bus.if_addr;
            r_size    <= FETCH_SIZE;
            r_lat     <= '0;
            r_streak  <= '0;
         end else if (w_busy) begin
            if (w_last) begin
               r_lat <= '0;
               if (r_owner_d) begin
                  if (!r_we) r_d_rdata <= bus.mem_rdata;
               end else begin
                  r_if_rdata <= bus.if_addr[2] ? bus.mem_rdata[63:32] : bus.mem_rdata[31:0];
               end
            end else begin
               r_lat <= r_lat + LW'(1);
            end
         end
      end
   end

   assign bus.mem_addr  = r_addr;
   assign bus.mem_wdata = r_wdata;
   assign bus.mem_size  = r_size;
   assign bus.mem_re    = w_mem_re;
   assign bus.mem_we    = w_mem_we;
   assign bus.if_done   = w_if_done;
   assign bus.d_done    = w_d_done;
   assign bus.if_rdata  = r_if_rdata;
   assign bus.d_rdata   = r_d_rdata;
   assign bus.stall_if  = bus.if_req & ~w_if_done;
   assign bus.stall_mem = bus.d_req & ~w_d_done;

endmodule
